rr_resource_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-owner resource among NUM_REQ requesters, e.g. a shared memory port or a multi-cycle execution unit.
- Winner selection is a rotating-priority trailing-one search over the request vector.
- A grant is held until the resource signals completion, then priority rotates past the winner.
- Back-to-back grants are issued with no idle bubble.

---
 rtl/rr_resource_arbiter.sv | 158 +++++++++++++++
 tb/tb_rr_resource_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter
//   Round-robin arbiter that shares one single-owner resource among NUM_REQ
//   requesters. The winner comes from a rotating-priority trailing-one search.
//   A grant is held until i_done, and then priority rotates past the winner.
//   When another requester is pending, the next grant is loaded with no idle cycle.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When this macro is defined, a watchdog revokes a grant after TIMEOUT_CYCLES
//     cycles without i_done, and o_timeout pulses for that cycle.
//     When this macro is undefined, there is no counter and o_timeout is tied to 0.
module rr_resource_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_done,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_gnt_valid,
  output logic                       o_timeout
);

  localparam int              IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [IDX_W-1:0]   gnt_idx_reg;
  logic [IDX_W-1:0]   ptr_reg;

  logic [IDX_W-1:0]   ptr_next;     // pointer value after the current owner finishes
  logic [IDX_W-1:0]   sel_ptr;      // pointer that is used by this cycle's search
  logic               handoff;      // current grant ends this cycle
  logic               timeout_hit;  // watchdog revoke this cycle
  logic [NUM_REQ-1:0] ge_mask;      // bits at positions >= sel_ptr
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] pick_vec;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;

  // Reject configurations outside the supported range at elaboration time.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("rr_resource_arbiter: NUM_REQ must be 2..32 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  // The pointer moves just past the finishing owner and wraps at the last requester.
  assign ptr_next = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + IDX_W'(1);

  // The grant ends on i_done, or on a watchdog revoke when that feature is built.
  assign handoff = (state_reg == GRANTED) && (i_done || timeout_hit);

  // Bypass: on a hand-off, arbitrate with the rotated pointer and not the stale one.
  assign sel_ptr = handoff ? ptr_next : ptr_reg;

  // Build the per-position mask and decode the winner to one-hot.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bit
      assign ge_mask[gi]    = (IDX_W'(gi) >= sel_ptr);
      assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Search the masked requests first, and fall back to the full vector when the mask is empty.
  always_comb begin
    masked_req = i_req & ge_mask;
    pick_vec   = (|masked_req) ? masked_req : i_req;
    win_found  = |i_req;
    win_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_reg;

  // The limit is reached only after TIMEOUT_CYCLES full cycles without i_done.
  // i_done has priority, so a coincident completion is not a timeout.
  assign timeout_hit = (state_reg == GRANTED) && !i_done &&
                       (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

  // The watchdog counts each granted cycle and restarts on every new grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == IDLE || handoff) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
    end
  end

  // The pulse is asserted in the revoke cycle itself, the same cycle in which i_done would act.
  assign o_timeout = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Grant state machine: load a winner from IDLE, hold it, and hand off on completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
      ptr_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // i_done is ignored here. The pointer moves only when a grant completes.
          if (win_found) begin
            gnt_reg     <= win_onehot;
            gnt_idx_reg <= win_idx;
            state_reg   <= GRANTED;
          end
        end
        GRANTED: begin
          // The grant is held while the request is low. Only a hand-off releases it.
          if (handoff) begin
            ptr_reg <= ptr_next;
            if (win_found) begin
              gnt_reg     <= win_onehot;
              gnt_idx_reg <= win_idx;
            end else begin
              gnt_reg     <= '0;
              gnt_idx_reg <= '0;
              state_reg   <= IDLE;
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          gnt_reg     <= '0;
          gnt_idx_reg <= '0;
        end
      endcase
    end
  end

  assign o_gnt       = gnt_reg;
  assign o_gnt_idx   = gnt_idx_reg;
  assign o_gnt_valid = (state_reg == GRANTED);

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed testbench for rr_resource_arbiter with NUM_REQ=4 and TIMEOUT_CYCLES=4.
// Each value is checked against an expected value that was worked out by hand.
module tb_rr_resource_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  rr_resource_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_done      (done),
    .o_gnt       (gnt),
    .o_gnt_idx   (gnt_idx),
    .o_gnt_valid (gnt_valid),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Wait for one rising edge and then 1 ns, so that the registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_idx,
                             input logic exp_valid);
    check_eq({tag, ".gnt"},   32'(gnt),       32'(exp_gnt));
    check_eq({tag, ".idx"},   32'(gnt_idx),   32'(exp_idx));
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
  endtask

  int fair_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    // Reset for 3 cycles, then release it with no requests.
    repeat (3) step();
    rst = 1'b0;
    step();
    check_grant("reset", 4'b0000, 2'd0, 1'b0);
    check_eq("reset.timeout", 32'(timeout), 32'd0);

    // Basic grant: ptr is 0, so the lowest requester (idx 1) wins.
    req = 4'b0110;
    step();
    check_grant("basic", 4'b0010, 2'd1, 1'b1);

    // Back-to-back: i_done moves ptr to 2, and idx 2 wins with no bubble.
    done = 1'b1;
    step();
    done = 1'b0;
    check_grant("b2b", 4'b0100, 2'd2, 1'b1);

    // Request drop: the grant to idx 2 is held while req is 0.
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("drop%0d.gnt", k), 32'(gnt), 32'b0100);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    check_grant("drop.idle", 4'b0000, 2'd0, 1'b0);

    // Wrap-around: ptr is 3 here.
    req = 4'b1000;
    step();
    check_grant("wrap.idx3", 4'b1000, 2'd3, 1'b1);
    req  = 4'b0001;
    done = 1'b1;
    step();
    check_grant("wrap.idx0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1001;
    step();
    done = 1'b0;
    check_grant("wrap.ptr1", 4'b1000, 2'd3, 1'b1);

    // Release to IDLE (ptr becomes 0), then hold i_done in IDLE. It must be ignored.
    req  = 4'b0000;
    done = 1'b1;
    step();
    check_eq("idle.valid", 32'(gnt_valid), 32'd0);
    step();
    step();
    done = 1'b0;
    check_eq("idle_done.valid", 32'(gnt_valid), 32'd0);

    // Fairness: all requesters active, and i_done is asserted in the 2nd cycle of each grant.
    req = 4'b1111;
    step();
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("fair%0d.idx", k), 32'(gnt_idx), 32'(fair_seq[k]));
      check_eq($sformatf("fair%0d.gnt", k), 32'(gnt), 32'(4'b0001 << fair_seq[k]));
      step();
      check_eq($sformatf("fair%0d.hold", k), 32'(gnt_valid), 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
    end
    check_grant("fair.after", 4'b0100, 2'd2, 1'b1);

    // Asynchronous reset in the middle of a grant: the grant drops with no clock edge.
    rst = 1'b1;
    #1;
    check_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_grant("post_rst.ptr0", 4'b0001, 2'd0, 1'b1);

    // Return to a known state: reset, then start from req=0011.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    step();
    check_grant("wd.grant0", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: after 4 idle cycles of the grant, the revoke cycle pulses o_timeout.
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq($sformatf("wd.c%0d.timeout", k), 32'(timeout), 32'd0);
      check_eq($sformatf("wd.c%0d.gnt", k), 32'(gnt), 32'b0001);
    end
    step();
    check_eq("wd.revoke.timeout", 32'(timeout), 32'd1);
    check_eq("wd.revoke.gnt", 32'(gnt), 32'b0001);
    step();
    check_grant("wd.next", 4'b0010, 2'd1, 1'b1);
    check_eq("wd.next.timeout", 32'(timeout), 32'd0);

    // i_done coincides with the timeout cycle: i_done wins, so there is no pulse.
    repeat (4) step();
    check_eq("wd.coinc.pre", 32'(timeout), 32'd1);
    done = 1'b1;
    #1;
    check_eq("wd.coinc.timeout", 32'(timeout), 32'd0);
    step();
    done = 1'b0;
    check_grant("wd.coinc.next", 4'b0001, 2'd0, 1'b1);
`else
    // No watchdog: the grant is held without limit, and o_timeout stays 0.
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 5 == 4) begin
        check_eq($sformatf("nowd.c%0d.gnt", k), 32'(gnt), 32'b0001);
        check_eq($sformatf("nowd.c%0d.timeout", k), 32'(timeout), 32'd0);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    check_grant("nowd.next", 4'b0010, 2'd1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
